// File: rtl/sha3_block_padder.sv
// SHA3-512 block padder: pops message bytes from the input FIFO,
// packs them into rate blocks and applies pad10*1 with suffix 0x06.
module sha3_block_padder #(
    parameter int RATE_BYTES = 72,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        msg_len,
    output logic                    busy,
    output logic                    fifo_rd,
    input  logic                    fifo_empty,
    input  logic [7:0]              fifo_data,
    output logic [RATE_BYTES*8-1:0] blk_data,
    output logic                    blk_valid,
    output logic                    blk_last,
    input  logic                    blk_ready,
    output logic                    done
);

    localparam int BW = RATE_BYTES * 8;
    localparam int PW = $clog2(RATE_BYTES + 1);
    localparam logic [PW-1:0] PTR_FULL = PW'(RATE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PAD,
        OUT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  rem;
    logic [PW-1:0]     byte_ptr;
    logic [PW-1:0]     cap_idx;
    logic              rd_pend;
    logic [BW-1:0]     pad_buf;
    logic              fetch_idle;

    // FETCH may only leave once no read is outstanding or being issued
    assign fetch_idle = !rd_pend && !fifo_rd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: begin
                if (fetch_idle) begin
                    if (byte_ptr == PTR_FULL) state_nx = OUT;
                    else if (rem == '0)       state_nx = PAD;
                end
            end
            PAD:   state_nx = OUT;
            OUT:   if (blk_ready) state_nx = blk_last ? DONE : FETCH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        fifo_rd   = (state == FETCH) && !fifo_empty &&
                    (rem != '0) && (byte_ptr != PTR_FULL);
        blk_valid = (state == OUT);
        done      = (state == DONE);
        busy      = (state != IDLE);
    end

    // Padded view of the buffer; both ORs land in one byte when the
    // message ends on the last slot, giving 0x86
    always_comb begin
        pad_buf = blk_data;
        pad_buf[{byte_ptr, 3'b000} +: 8] =
            pad_buf[{byte_ptr, 3'b000} +: 8] | 8'h06;
        pad_buf[BW-1 -: 8] = pad_buf[BW-1 -: 8] | 8'h80;
    end

    // Byte counters, capture of FIFO data and block buffer updates
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_data <= '0;
            blk_last <= 1'b0;
            rem      <= '0;
            byte_ptr <= '0;
            cap_idx  <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= fifo_rd;
            if (fifo_rd) begin
                cap_idx  <= byte_ptr;
                byte_ptr <= byte_ptr + PW'(1);
                rem      <= rem - LEN_W'(1);
            end
            if (rd_pend)
                blk_data[{cap_idx, 3'b000} +: 8] <= fifo_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= msg_len;
                        byte_ptr <= '0;
                        blk_data <= '0;
                    end
                end
                FETCH: begin
                    if (fetch_idle && byte_ptr == PTR_FULL)
                        blk_last <= 1'b0;
                end
                PAD: begin
                    blk_data <= pad_buf;
                    blk_last <= 1'b1;
                end
                OUT: begin
                    if (blk_ready && !blk_last) begin
                        blk_data <= '0;
                        byte_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_block_padder.sv
// Bench for sha3_block_padder: FIFO model, expected-block scoreboard,
// random FIFO bubbles, consumer stalls and mid-message reset.
module tb_sha3_block_padder;

    typedef struct {
        logic [575:0] d;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  msg_len;
    logic         busy;
    logic         fifo_rd;
    logic         fifo_empty = 1'b1;
    logic [7:0]   fifo_data = 8'h00;
    logic [575:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready = 1'b1;
    logic         done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int hold = 0;
    bit rnd_empty = 0;
    bit stall_mode = 0;
    bit was_stalled = 0;
    logic [575:0] held_d;
    logic         held_l;

    logic [7:0] fifo_q[$];
    logic [7:0] msg[$];
    blk_t       exp_q[$];

    sha3_block_padder #(.RATE_BYTES(72), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_len    (msg_len),
        .busy       (busy),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last),
        .blk_ready  (blk_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] got,
                       input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO model: registered data out, optional random empty bubbles
    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_data <= fifo_q.pop_front();
            rd_cnt++;
        end
        #1;
        fifo_empty = (fifo_q.size() == 0) ||
                     (rnd_empty && $urandom_range(0, 2) == 0);
    end

    // Consumer: optionally holds ready low for 5 cycles per block
    always @(posedge clk) begin
        #1;
        if (stall_mode && blk_valid && hold < 5) begin
            blk_ready = 1'b0;
            hold++;
        end else begin
            blk_ready = 1'b1;
        end
        if (!blk_valid) hold = 0;
    end

    // Monitor: scoreboard compare on handshake, stability while stalled
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (fifo_rd) chk("rd_when_empty", 576'(fifo_empty), 576'(0));
            if (blk_valid) begin
                chk("no_rd_in_out", 576'(fifo_rd), 576'(0));
                if (was_stalled) begin
                    chk("stall_data", blk_data, held_d);
                    chk("stall_last", 576'(blk_last), 576'(held_l));
                end
                if (blk_ready) begin
                    was_stalled = 0;
                    chk("blk_expected", 576'(exp_q.size() != 0), 576'(1));
                    if (exp_q.size() != 0) begin
                        blk_t e;
                        e = exp_q.pop_front();
                        chk("blk_data", blk_data, e.d);
                        chk("blk_last", 576'(blk_last), 576'(e.last));
                    end
                end else begin
                    was_stalled = 1;
                    held_d = blk_data;
                    held_l = blk_last;
                end
            end else begin
                was_stalled = 0;
            end
        end
    end

    task automatic run_msg(input int len, input int extra);
        int nb;
        int p;
        int cyc;
        logic [575:0] b;
        @(posedge clk);
        #2;
        nb = (len + 72) / 72;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 72; j++)
                if (k * 72 + j < len) b[j*8 +: 8] = msg[k*72 + j];
            if (k == nb - 1) begin
                p = len - k * 72;
                b[p*8 +: 8] = b[p*8 +: 8] | 8'h06;
                b[575:568] = b[575:568] | 8'h80;
            end
            exp_q.push_back('{d: b, last: (k == nb - 1)});
        end
        for (int i = 0; i < len; i++) fifo_q.push_back(msg[i]);
        for (int i = 0; i < extra; i++) fifo_q.push_back(8'h99);
        rd_cnt = 0;
        done_cnt = 0;
        @(posedge clk);
        #2;
        msg_len = 16'(len);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 576'(busy), 576'(1));
        cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_pulses", 576'(done_cnt), 576'(1));
        chk("fifo_reads", 576'(rd_cnt), 576'(len));
        chk("blocks_left", 576'(exp_q.size()), 576'(0));
        chk("busy_end", 576'(busy), 576'(0));
        chk("fifo_left", 576'(fifo_q.size()), 576'(extra));
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic set_msg(input int n, input logic [7:0] base);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(base + 8'(i));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        msg_len = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 576'(blk_valid), 576'(0));
        chk("rst_last", 576'(blk_last), 576'(0));
        chk("rst_done", 576'(done), 576'(0));
        chk("rst_busy", 576'(busy), 576'(0));
        chk("rst_rd", 576'(fifo_rd), 576'(0));
        chk("rst_data", blk_data, 576'(0));
        rst = 1'b0;

        set_msg(0, 8'h00);
        run_msg(0, 0);

        set_msg(3, 8'h61);
        run_msg(3, 1);

        set_msg(71, 8'h00);
        run_msg(71, 0);

        set_msg(72, 8'h00);
        run_msg(72, 0);

        rnd_empty = 1;
        stall_mode = 1;
        set_msg(150, 8'h00);
        run_msg(150, 0);
        rnd_empty = 0;
        stall_mode = 0;

        @(posedge clk);
        #2;
        for (int i = 0; i < 100; i++) fifo_q.push_back(8'(i));
        @(posedge clk);
        #2;
        msg_len = 16'd100;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("mid_busy", 576'(busy), 576'(1));
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mrst_valid", 576'(blk_valid), 576'(0));
        chk("mrst_last", 576'(blk_last), 576'(0));
        chk("mrst_done", 576'(done), 576'(0));
        chk("mrst_busy", 576'(busy), 576'(0));
        chk("mrst_rd", 576'(fifo_rd), 576'(0));
        chk("mrst_data", blk_data, 576'(0));
        @(negedge clk);
        fifo_q.delete();
        fifo_empty = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;

        set_msg(3, 8'h61);
        run_msg(3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_block_padder.md
Name: sha3_block_padder

Overview:
- Sits directly downstream of the 8-bit input FIFO in the SHA3-512 datapath.
- Pops message bytes from the FIFO, packs them into 72-byte (576-bit) rate blocks and applies SHA3 pad10*1 with domain suffix 0x06.
- Presents each block to the Keccak absorb/permutation stage over a valid/ready handshake.
- Block count per message is ceil((msg_len+1)/72).

Parameters:
- RATE_BYTES, 72: rate in bytes (SHA3-512); block width is RATE_BYTES*8.
- LEN_W, 16: width of the message length in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle pulse that begins a message. Ignored while busy.
- msg_len  in  LEN_W  message length in bytes, sampled on an accepted start.
- busy  out  1  high from the accepted start until the cycle done is asserted, inclusive.
- fifo_rd  out  1  FIFO read strobe (combinational).
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_data  in  8  FIFO dataOut, valid the cycle after an accepted read.
- blk_data  out  RATE_BYTES*8  block; byte i at bits [8i+7:8i] (Keccak little-endian lanes).
- blk_valid  out  1  block valid.
- blk_last  out  1  qualifies blk_valid: final, padded block of the message.
- blk_ready  in  1  consumer accepts the block when blk_valid & blk_ready.
- done  out  1  one-cycle pulse after the last block handshake.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE and sets blk_data=0, blk_valid=0, blk_last=0, done=0, busy=0, rem=0, byte_ptr=0, rd_pend=0. fifo_rd is 0 in IDLE.
- Reset mid-operation: any in-flight FIFO byte is discarded. The FIFO is reset alongside by the top level.
- Registers:
  - rem: message bytes not yet requested.
  - byte_ptr (0..RATE_BYTES): bytes requested into the current block.
  - rd_pend: a read was issued last cycle.
  - cap_idx: slot for the pending byte.
- States: IDLE, FETCH, PAD, OUT, DONE.
- IDLE:
  - On start: rem<=msg_len, byte_ptr<=0, buffer<=0, busy<=1, go to FETCH.
- FETCH:
  - fifo_rd = !fifo_empty & rem!=0 & byte_ptr!=RATE_BYTES.
  - On fifo_rd: cap_idx<=byte_ptr, byte_ptr++, rem--, rd_pend<=1; otherwise rd_pend<=0.
  - When rd_pend: buffer[cap_idx]<=fifo_data.
  - Sustained throughput is 1 byte/cycle. An empty FIFO inserts bubbles only.
- FETCH exit, evaluated in priority order, only when rd_pend=0 and fifo_rd=0:
  1. byte_ptr==RATE_BYTES: go to OUT with blk_last=0.
  2. Else rem==0: go to PAD.
- PAD (one cycle):
  - Bytes byte_ptr..RATE_BYTES-1 are already 0.
  - buffer[byte_ptr] |= 0x06 and buffer[RATE_BYTES-1] |= 0x80.
  - byte_ptr==RATE_BYTES-1 therefore yields 0x86.
  - Go to OUT with blk_last=1.
- OUT:
  - blk_valid=1. blk_data and blk_last are held stable until handshake. fifo_rd=0.
  - On handshake with blk_last=1: blk_valid<=0, go to DONE.
  - On handshake with blk_last=0: buffer<=0, byte_ptr<=0, go to FETCH.
- DONE:
  - done=1 for one cycle, busy<=0, go to IDLE.
  - A start in this cycle is ignored.
- msg_len a multiple of RATE_BYTES, including 0: after the full data blocks, a separate block is emitted with byte0=0x06, byte71=0x80, all others 0.
- The block never pops more than msg_len bytes from the FIFO; bytes beyond msg_len stay queued.
- blk_data is visible only while blk_valid. Its content outside OUT is don't-care.

Test Plan:
- msg_len=0, start -> exactly 0 FIFO reads. One block with blk_last=1: byte0=0x06, byte71=0x80, rest 0. done pulses once.
- msg_len=3, FIFO holds 0x61 0x62 0x63 -> one block: bytes0..2=61 62 63, byte3=06, bytes4..70=00, byte71=80, blk_last=1. Exactly 3 fifo_rd cycles.
- msg_len=71, bytes 0x00..0x46 -> one block: bytes0..70 = 0x00..0x46 in order, byte71=0x86, blk_last=1.
- msg_len=72, bytes 0x00..0x47 -> block1 (blk_last=0) = 0x00..0x47. Block2 (blk_last=1) = 06, 70×00, 80.
- fifo_empty toggled pseudo-randomly, blk_ready held low 5 cycles in OUT, msg_len=150 -> blk_data stable while stalled, no fifo_rd during OUT. Blocks 1 and 2 carry bytes 0..143 unchanged. Block 3 = bytes 144..149, then 06, zeros, 80.
- rst asserted mid-FETCH of a 100-byte message, then start with msg_len=3 -> all outputs 0 the cycle after rst. The new message produces the same block as the msg_len=3 test.
